ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the PC and address width.
REQ-002 Parameter RESET_PC, default 64'h0000_0000_8000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-low reset.
REQ-005 imem_req_valid  output  1  SHALL flag a fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-007 imem_req_addr  output  WIDTH  SHALL carry the fetch address.
REQ-008 imem_resp_valid  input  1  SHALL flag returned instruction data.
REQ-009 imem_resp_data  input  32  SHALL carry the returned instruction.
REQ-010 redirect_valid  input  1  SHALL flag a taken branch, jump or trap redirect.
REQ-011 redirect_pc  input  WIDTH  SHALL carry the redirect target.
REQ-012 if_valid  output  1  SHALL flag a valid instruction to decode.
REQ-013 if_ready  input  1  SHALL flag that decode consumes the instruction this cycle.
REQ-014 if_pc  output  WIDTH  SHALL carry the PC of if_inst.
REQ-015 if_inst  output  32  SHALL carry the fetched instruction.
REQ-016 if_ex  output  1  SHALL flag an instruction-address-misaligned fetch.

Function
REQ-017 States SHALL be REQ, WAIT and HOLD, plus a 1-bit kill flag.
REQ-018 REQ: imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready, next state is WAIT.
REQ-019 WAIT: on imem_resp_valid with kill=0, the block SHALL register data into if_inst and pc into if_pc, and enter HOLD.
REQ-020 WAIT: on imem_resp_valid with kill=1, the block SHALL discard the response, clear kill and enter REQ.
REQ-021 HOLD: if_valid=1; on if_ready, pc advances to pc+4 and the next state is REQ.
REQ-022 if_valid SHALL be 1 only in HOLD; if_pc, if_inst and if_ex SHALL stay stable while if_valid=1 and if_ready=0.
REQ-023 Minimum latency from request acceptance to if_valid SHALL be 1 cycle after imem_resp_valid.
REQ-024 redirect_valid SHALL have highest priority and load pc<=redirect_pc in every state.
REQ-025 Redirect in REQ without handshake: the state stays REQ and the next request uses the new pc.
REQ-026 Redirect in REQ with handshake in the same cycle: the state enters WAIT with kill=1.
REQ-027 Redirect in WAIT without a response: kill is set to 1 and the state stays WAIT.
REQ-028 Redirect in WAIT with a response in the same cycle: the response is discarded and the state enters REQ.
REQ-029 Redirect in HOLD: the buffered instruction is dropped, so if_valid=0 next cycle, and the state enters REQ.
REQ-030 Redirect in HOLD with if_ready in the same cycle: the handshake completes and pc takes redirect_pc, not pc+4.
REQ-031 PC arithmetic SHALL be WIDTH-bit modulo; pc+4 wraps at 2^WIDTH without a flag.
REQ-032 At most one request SHALL be outstanding; imem_req_valid SHALL stay 0 in WAIT and HOLD.

Reset
REQ-033 While rst=0 at a clock edge, the block SHALL set state=REQ, pc=RESET_PC, kill=0, if_inst=0, if_pc=RESET_PC and if_ex=0.
REQ-034 imem_req_valid and if_valid SHALL be 0 while rst=0; imem_req_valid SHALL rise in the first cycle after rst is sampled 1.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request, and a late response SHALL be ignored until a new request is accepted.

Configuration
REQ-036 Macro IFU_MISALIGN_EX_EN defined: a redirect with redirect_pc[1:0]!=0 issues no fetch; the state enters HOLD with if_pc=redirect_pc, if_inst=32'h00000013 and if_ex=1, and if_ready returns the state to REQ with pc unchanged until the next redirect.
REQ-037 Macro IFU_MISALIGN_EX_EN undefined: redirect_pc[1:0] is forced to 2'b00 when loaded, and if_ex is tied to 0.

Verification
REQ-038 Reset release, req_ready=1, resp one cycle later with 32'h00000293, if_ready=1 -> if_valid with if_pc=0x80000000 and if_inst=0x00000293, then the next req_addr is 0x80000004.
REQ-039 if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_inst held, and no new request.
REQ-040 Redirect to 0x80001000 in WAIT before the response -> the stale response is dropped and the next req_addr is 0x80001000.
REQ-041 Redirect to 0x80002000 together with if_ready in HOLD -> the next req_addr is 0x80002000, not pc+4.
REQ-042 IFU_MISALIGN_EX_EN defined, redirect to 0x80000002 -> if_valid=1, if_ex=1, if_pc=0x80000002, if_inst=0x00000013, and no imem request.
REQ-043 rst=0 asserted in WAIT, then released, then the old response arrives -> the response is ignored and a new request goes to RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> HOLD with a kill flag
// that discards responses to redirected fetches. Define IFU_MISALIGN_EX_EN to raise
// if_ex on misaligned redirect targets instead of forcing them to word alignment.
module ifu_fetch #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(64'h0000_0000_8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_inst,
  output logic             if_ex
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               kill_q, kill_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   if_pc_q, if_pc_d;
  logic [31:0]        if_inst_q, if_inst_d;
  logic [WIDTH-1:0]   redir_tgt;

`ifdef IFU_MISALIGN_EX_EN
  logic               if_ex_q, if_ex_d;
  logic               redir_mis;

  assign redir_tgt = redirect_pc;
  assign redir_mis = (redirect_pc[1:0] != 2'b00);
  assign if_ex     = if_ex_q;
`else
  assign redir_tgt = redirect_pc & ~WIDTH'(3);
  assign if_ex     = 1'b0;
`endif

  assign imem_req_valid = rst && (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = rst && (state_q == ST_HOLD);
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
`ifdef IFU_MISALIGN_EX_EN
    if_ex_d   = if_ex_q;
    // A misaligned redirect can leave a stale response in flight outside WAIT.
    if (state_q != ST_WAIT && imem_resp_valid && kill_q) kill_d = 1'b0;
`endif

    unique case (state_q)
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if_pc_d   = pc_q;
            if_inst_d = imem_resp_data;
`ifdef IFU_MISALIGN_EX_EN
            if_ex_d   = 1'b0;
`endif
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (if_ready) begin
          state_d = ST_REQ;
`ifdef IFU_MISALIGN_EX_EN
          if (!if_ex_q) pc_d = pc_q + WIDTH'(4);
`else
          pc_d = pc_q + WIDTH'(4);
`endif
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides the normal transition; a request already accepted
    // (or still in flight) must have its response discarded.
    if (redirect_valid) begin
      pc_d = redir_tgt;
      unique case (state_q)
        ST_REQ:  if (imem_req_ready) kill_d = 1'b1;
        ST_WAIT: begin
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
`ifdef IFU_MISALIGN_EX_EN
      if (redir_mis) begin
        state_d   = ST_HOLD;
        if_pc_d   = redirect_pc;
        if_inst_d = 32'h0000_0013;
        if_ex_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_REQ;
      kill_q    <= 1'b0;
      pc_q      <= RESET_PC;
      if_pc_q   <= RESET_PC;
      if_inst_q <= '0;
`ifdef IFU_MISALIGN_EX_EN
      if_ex_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      pc_q      <= pc_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
`ifdef IFU_MISALIGN_EX_EN
      if_ex_q   <= if_ex_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written wrap
// sequence, then randomized traffic against a queue-based fetch model.
module tb_ifu_fetch;

  localparam logic [63:0] R = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ex;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(.WIDTH(64), .RESET_PC(R)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_ex(if_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, rsp;
    logic [31:0] data;
    logic        rdr;
    logic [63:0] rpc;
    logic        ifr;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_ex;
    logic        chk_buf;
  } vec_t;

  typedef struct { logic [63:0] addr; logic stale; } pend_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } buf_t;
  typedef struct { logic [63:0] addr; int unsigned d; } mem_t;

  function automatic vec_t v(logic rs, logic rdy, logic rsp, logic [31:0] data,
                             logic rdr, logic [63:0] rpc, logic ifr,
                             logic e_rv, logic [63:0] e_addr, logic e_iv,
                             logic [63:0] e_pc, logic [31:0] e_inst, logic e_ex,
                             logic chk_buf);
    vec_t t;
    t.rst = rs; t.rdy = rdy; t.rsp = rsp; t.data = data; t.rdr = rdr; t.rpc = rpc;
    t.ifr = ifr; t.e_rv = e_rv; t.e_addr = e_addr; t.e_iv = e_iv; t.e_pc = e_pc;
    t.e_inst = e_inst; t.e_ex = e_ex; t.chk_buf = chk_buf;
    return t;
  endfunction

  function automatic logic [31:0] mdat(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; imem_req_ready = t.rdy; imem_resp_valid = t.rsp;
    imem_resp_data = t.data; redirect_valid = t.rdr; redirect_pc = t.rpc;
    if_ready = t.ifr;
    #1;
    chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'(t.e_rv));
    if (t.e_rv) chk({tag, ".req_addr"}, imem_req_addr, t.e_addr);
    chk({tag, ".if_valid"}, 64'(if_valid), 64'(t.e_iv));
    if (t.e_iv || t.chk_buf) begin
      chk({tag, ".if_pc"}, if_pc, t.e_pc);
      chk({tag, ".if_inst"}, 64'(if_inst), 64'(t.e_inst));
      chk({tag, ".if_ex"}, 64'(if_ex), 64'(t.e_ex));
    end
  endtask

  vec_t  tbl[$];
  pend_t pend[$];
  buf_t  bq[$];
  mem_t  mq[$];

  initial begin
    logic [63:0] m_pc, old_pc, tgt;
    logic        e_rv, e_iv, hs;
    pend_t       p;
    mem_t        me;
    buf_t        b;

    // rst,rdy,rsp,data,rdr,rpc,ifr | rv,addr,iv,pc,inst,ex,chk
    tbl.push_back(v(0,0,0,0,0,0,0, 0,R,0,R,0,0,1));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,R,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'h293,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,1, 0,0,1,R,32'h293,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,R+4,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,R+4,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'h0010_0093,0,0,0, 0,0,0,0,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1,0,0,0,0,0,0, 0,0,1,R+4,32'h0010_0093,0,1));
    tbl.push_back(v(1,0,0,0,0,0,1, 0,0,1,R+4,32'h0010_0093,0,1));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,R+8,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,1,64'h8000_1000,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'hDEAD,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,64'h8000_1000,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,64'h8000_1000,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'h13579,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,1,64'h8000_2000,1, 0,0,1,64'h8000_1000,32'h13579,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,64'h8000_2000,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,64'h8000_2000,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'hBAD,0,0,0, 1,R,0,R,0,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,R,0,R,0,0,1));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,R,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'h293,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,1,R,32'h293,0,1));
    tbl.push_back(v(1,0,0,0,1,64'h8000_3000,0, 0,0,1,R,32'h293,0,1));
    tbl.push_back(v(1,1,0,0,1,64'h8000_4000,0, 1,64'h8000_3000,0,0,0,0,0));
    tbl.push_back(v(1,0,1,32'h111,1,64'h8000_5000,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,1,64'h8000_6002,0, 1,64'h8000_5000,0,0,0,0,0));
`ifdef IFU_MISALIGN_EX_EN
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,1,64'h8000_6002,32'h13,1,1));
    tbl.push_back(v(1,0,0,0,0,0,1, 0,0,1,64'h8000_6002,32'h13,1,1));
    tbl.push_back(v(1,0,0,0,1,64'h8000_7000,0, 1,64'h8000_6002,0,0,0,0,0));
`else
    tbl.push_back(v(1,0,0,0,0,0,0, 1,64'h8000_6000,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,1, 1,64'h8000_6000,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,1,64'h8000_7000,0, 1,64'h8000_6000,0,0,0,0,0));
`endif
    tbl.push_back(v(1,0,0,0,0,0,0, 1,64'h8000_7000,0,0,0,0,0));

    rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // PC wrap at 2^64 without any flag
    apply(v(1,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFC,0, 1,64'h8000_7000,0,0,0,0,0), "wrap0");
    apply(v(1,1,0,0,0,0,0, 1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0,0,0), "wrap1");
    apply(v(1,0,1,32'hABCD,0,0,0, 0,0,0,0,0,0,0), "wrap2");
    apply(v(1,0,0,0,0,0,1, 0,0,1,64'hFFFF_FFFF_FFFF_FFFC,32'hABCD,0,1), "wrap3");
    apply(v(1,0,0,0,0,0,0, 1,64'h0,0,0,0,0,0), "wrap4");

    // Randomized traffic against a transaction-level model
    m_pc = R;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst            = (cyc < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
      imem_req_ready = $urandom_range(0, 1);
      redirect_valid = ($urandom_range(0, 9) == 0);
      tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
`ifdef IFU_MISALIGN_EX_EN
      tgt[1:0] = 2'b00;
`endif
      redirect_pc    = tgt;
      if_ready       = ($urandom_range(0, 4) < 3);
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mq.size() != 0) begin
        if (mq[0].d == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mdat(mq[0].addr);
        end else begin
          mq[0].d = mq[0].d - 1;
        end
      end
      #1;
      e_rv = rst && pend.size() == 0 && bq.size() == 0;
      e_iv = rst && bq.size() != 0;
      chk($sformatf("rnd%0d.req_valid", cyc), 64'(imem_req_valid), 64'(e_rv));
      if (e_rv) chk($sformatf("rnd%0d.req_addr", cyc), imem_req_addr, m_pc);
      chk($sformatf("rnd%0d.if_valid", cyc), 64'(if_valid), 64'(e_iv));
      if (e_iv) begin
        chk($sformatf("rnd%0d.if_pc", cyc), if_pc, bq[0].pc);
        chk($sformatf("rnd%0d.if_inst", cyc), 64'(if_inst), 64'(bq[0].inst));
        chk($sformatf("rnd%0d.if_ex", cyc), 64'(if_ex), 64'(0));
      end

      if (!rst) begin
        m_pc = R;
        pend.delete(); bq.delete(); mq.delete();
      end else begin
        old_pc = m_pc;
        hs = e_rv && imem_req_ready;
        if (!redirect_valid && bq.size() != 0 && if_ready) begin
          void'(bq.pop_front());
          m_pc = m_pc + 64'd4;
        end
        if (redirect_valid) begin
          foreach (pend[k]) pend[k].stale = 1'b1;
          bq.delete();
          m_pc = redirect_pc & ~64'd3;
        end
        if (imem_resp_valid) begin
          void'(mq.pop_front());
          if (pend.size() != 0) begin
            p = pend.pop_front();
            if (!p.stale) begin
              b.pc = p.addr; b.inst = imem_resp_data;
              bq.push_back(b);
            end
          end
        end
        if (hs) begin
          p.addr = old_pc; p.stale = redirect_valid;
          pend.push_back(p);
          me.addr = old_pc; me.d = $urandom_range(0, 3);
          mq.push_back(me);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
